// File: rtl/spi_slave_sampler.sv
// spi_slave_sampler
//   SPI slave front end, mode 0 (CPOL=0, CPHA=0), MSB first. Synchronises the
//   asynchronous pad inputs into the clk domain, regenerates one-cycle SCLK edge
//   strobes, deserialises MOSI into rx_data and serialises tx_data onto MISO.
//
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   en                 block enable; low holds the block idle
//   err_clr            clears the sticky rx_overrun / tx_underrun flags
//   spi_sclk/cs_n/mosi asynchronous pad inputs
//   spi_miso/_oe       serial data out and its pad output enable
//   spi_rise/_fall     one-cycle strobes on qualified SCLK edges
//   rx_data/valid/ready  received word, valid/ready handshake
//   tx_data/valid      next word to send
//   tx_ready           one-cycle load strobe; the word is taken if tx_valid is high
//   rx_overrun         sticky: a word completed while rx_valid was still pending
//   tx_underrun        sticky: a load happened with tx_valid low

module spi_slave_sampler #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  err_clr,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic                  spi_rise,
  output logic                  spi_fall,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  rx_overrun,
  output logic                  tx_underrun
);

  localparam int unsigned CntW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e                  state_q;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                    sclk_d_q, cs_d_q;
  logic                    spi_rise_q, spi_fall_q;
  logic [CntW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0]   rx_shift_q, tx_shift_q, rx_data_q;
  logic                    rx_valid_q, word_done_q;
  logic                    rx_overrun_q, tx_underrun_q;

  logic                    sclk_s, cs_s, mosi_s;
  logic                    sclk_rise, sclk_fall, cs_fall;
  logic                    stay_active, start, rise_ev, fall_ev, word_end, load_ev;
  logic [DATA_WIDTH-1:0]   rx_shift_nxt;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_comb begin
    sclk_rise    = sclk_s & ~sclk_d_q;
    sclk_fall    = ~sclk_s & sclk_d_q;
    cs_fall      = ~cs_s & cs_d_q;
    // Leaving ACTIVE takes effect in the same cycle: no edge is acted on once
    // cs_s or en drops.
    stay_active  = (state_q == StActive) & en & ~cs_s;
    start        = (state_q == StIdle) & en & cs_fall;
    rise_ev      = stay_active & sclk_rise;
    fall_ev      = stay_active & sclk_fall;
    word_end     = rise_ev & (bit_cnt_q == LastBit);
    // A completed word turns the next falling edge into a reload instead of a shift.
    load_ev      = start | (fall_ev & word_done_q);
    rx_shift_nxt = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_d_q      <= 1'b0;
      cs_d_q        <= 1'b1;
      state_q       <= StIdle;
      spi_rise_q    <= 1'b0;
      spi_fall_q    <= 1'b0;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      word_done_q   <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_d_q    <= sclk_s;
      cs_d_q      <= cs_s;

      spi_rise_q <= rise_ev;
      spi_fall_q <= fall_ev;

      unique case (state_q)
        StIdle:   if (start) state_q <= StActive;
        StActive: if (!stay_active) state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase

      // Receive path; any partial word is dropped whenever the frame is not active.
      if (!stay_active) begin
        bit_cnt_q   <= '0;
        rx_shift_q  <= '0;
        word_done_q <= 1'b0;
      end else if (rise_ev) begin
        rx_shift_q <= rx_shift_nxt;
        if (word_end) begin
          bit_cnt_q   <= '0;
          word_done_q <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end else if (load_ev) begin
        word_done_q <= 1'b0;
      end

      // A completion takes priority over a same-cycle consume, so rx_valid stays set.
      if (word_end) begin
        rx_data_q  <= rx_shift_nxt;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      // Transmit path.
      if (load_ev) begin
        tx_shift_q <= tx_valid ? tx_data : '0;
      end else if (fall_ev) begin
        tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
      end

      // Sticky flags: a set event wins over err_clr.
      if (word_end && rx_valid_q && !rx_ready) begin
        rx_overrun_q <= 1'b1;
      end else if (err_clr) begin
        rx_overrun_q <= 1'b0;
      end

      if (load_ev && !tx_valid) begin
        tx_underrun_q <= 1'b1;
      end else if (err_clr) begin
        tx_underrun_q <= 1'b0;
      end
    end
  end

  assign spi_miso    = tx_shift_q[DATA_WIDTH-1];
  assign spi_miso_oe = (state_q == StActive);
  assign spi_rise    = spi_rise_q;
  assign spi_fall    = spi_fall_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = load_ev;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_sampler.sv
module tb_spi_slave_sampler;

  localparam int unsigned W    = 8;
  localparam int          HALF = 6;  // SCLK half period in clk cycles

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         err_clr = 1'b0;
  logic         spi_sclk = 1'b0;
  logic         spi_cs_n = 1'b1;
  logic         spi_mosi = 1'b0;
  logic         spi_miso, spi_miso_oe, spi_rise, spi_fall;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready, rx_overrun, tx_underrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_rx_q[$];
  logic         exp_miso_q[$];

  int           tx_ready_cnt = 0;
  int           strobe_cnt = 0;
  logic         prev_valid = 1'b0;
  logic [W-1:0] prev_data = '0;

  spi_slave_sampler #(
    .DATA_WIDTH (W),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .err_clr    (err_clr),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .spi_rise   (spi_rise),
    .spi_fall   (spi_fall),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_overrun (rx_overrun),
    .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: MISO bits are checked at each rise strobe, a received word
  // is popped whenever rx_valid rises or rx_data changes.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = rx_valid;
      prev_data  = rx_data;
    end else begin
      if (tx_ready) tx_ready_cnt++;
      if (spi_rise || spi_fall) strobe_cnt++;
      if (spi_rise && exp_miso_q.size() > 0) check("miso_bit", spi_miso, exp_miso_q.pop_front());
      if ((rx_valid && !prev_valid) || (rx_data != prev_data)) begin
        if (exp_rx_q.size() == 0) check("rx_unexpected_word", exp_rx_q.size(), 1);
        else check("rx_data", rx_data, exp_rx_q.pop_front());
      end
      prev_valid = rx_valid;
      prev_data  = rx_data;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    spi_cs_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic end_frame(input bit sclk_high);
    wait_clks(HALF);
    spi_cs_n = 1'b1;
    wait_clks(HALF);
    if (sclk_high) begin
      spi_sclk = 1'b0;
      wait_clks(HALF);
    end
  endtask

  // Shift nbits of d (MSB first). ready_pulse raises rx_ready for exactly the
  // cycle in which the last bit completes the word.
  task automatic send_word(input logic [W-1:0] d, input int nbits, input bit last_fall,
                           input bit ready_pulse);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = d[W-1-i];
      wait_clks(HALF);
      spi_sclk = 1'b1;
      if (ready_pulse && i == nbits - 1) begin
        wait_clks(2);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        wait_clks(HALF - 3);
      end else begin
        wait_clks(HALF);
      end
      if (i < nbits - 1 || last_fall) spi_sclk = 1'b0;
    end
  endtask

  task automatic push_miso(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) exp_miso_q.push_back(d[i]);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    wait_clks(2);
  endtask

  initial begin
    // Reset state
    wait_clks(3);
    check("rst_outputs", {spi_miso, spi_miso_oe, spi_rise, spi_fall, rx_valid, tx_ready,
                          rx_overrun, tx_underrun}, 0);
    check("rst_rx_data", rx_data, 0);
    rst = 1'b0;
    en  = 1'b1;
    wait_clks(4);

    // 1: single word, MISO A5 / MOSI 3C, frame ends with SCLK still high
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    tx_ready_cnt = 0;
    exp_rx_q.push_back(8'h3C);
    push_miso(8'hA5);
    start_frame();
    check("t1_oe", spi_miso_oe, 1);
    send_word(8'h3C, W, 1'b0, 1'b0);
    end_frame(1'b1);
    check("t1_rx_valid", rx_valid, 1);
    check("t1_tx_ready_pulses", tx_ready_cnt, 1);
    check("t1_oe_after", spi_miso_oe, 0);
    consume();
    check("t1_consumed", rx_valid, 0);

    // 2: back-to-back words with no consumer -> overrun, then err_clr
    tx_data = 8'h0F;
    exp_rx_q.push_back(8'h12);
    exp_rx_q.push_back(8'h34);
    start_frame();
    send_word(8'h12, W, 1'b1, 1'b0);
    send_word(8'h34, W, 1'b1, 1'b0);
    end_frame(1'b0);
    check("t2_rx_data", rx_data, 8'h34);
    check("t2_overrun", rx_overrun, 1);
    err_clr = 1'b1;
    wait_clks(1);
    err_clr = 1'b0;
    wait_clks(1);
    check("t2_overrun_clr", rx_overrun, 0);
    consume();

    // 3: aborted partial word, then a full word
    start_frame();
    send_word(8'hAA, 5, 1'b1, 1'b0);
    end_frame(1'b0);
    check("t3_no_partial", rx_valid, 0);
    exp_rx_q.push_back(8'hF0);
    start_frame();
    send_word(8'hF0, W, 1'b1, 1'b0);
    end_frame(1'b0);
    check("t3_rx_valid", rx_valid, 1);
    check("t3_underrun_clear", tx_underrun, 0);
    consume();

    // 4: tx_valid low at frame start -> underrun, MISO stays 0
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    exp_rx_q.push_back(8'h5A);
    push_miso(8'h00);
    start_frame();
    check("t4_oe", spi_miso_oe, 1);
    check("t4_underrun", tx_underrun, 1);
    send_word(8'h5A, W, 1'b1, 1'b0);
    end_frame(1'b0);
    tx_valid = 1'b1;
    consume();

    // 6: completion in the same cycle as rx_ready -> stays valid, no overrun
    exp_rx_q.push_back(8'h66);
    exp_rx_q.push_back(8'h99);
    start_frame();
    send_word(8'h66, W, 1'b1, 1'b0);
    send_word(8'h99, W, 1'b1, 1'b1);
    end_frame(1'b0);
    check("t6_rx_valid", rx_valid, 1);
    check("t6_no_overrun", rx_overrun, 0);
    consume();
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("miso_queue_drained", exp_miso_q.size(), 0);

    // 5: disabled block ignores SCLK, then reset in the middle of a word
    en = 1'b0;
    strobe_cnt = 0;
    spi_cs_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 4; i++) begin
      spi_sclk = ~spi_sclk;
      wait_clks(HALF);
    end
    check("t5_no_strobes", strobe_cnt, 0);
    check("t5_oe_disabled", spi_miso_oe, 0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    en = 1'b1;
    wait_clks(HALF);
    start_frame();
    send_word(8'hC3, 4, 1'b0, 1'b0);
    rst = 1'b1;
    wait_clks(1);
    check("t5_rst_outputs", {spi_miso, spi_miso_oe, spi_rise, spi_fall, rx_valid, tx_ready,
                             rx_overrun, tx_underrun}, 0);
    check("t5_rst_rx_data", rx_data, 0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(HALF);
    check("t5_no_word_after_rst", rx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
